// File: rtl/uart_mon_pkg.sv
// Shared types and defaults for the UART monitor framer.
// Holds the frame header default and the framer state encoding.
package uart_mon_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        SEQ,
        DATA
    } mon_state_t;

endpackage

// File: rtl/mon_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
// Read data is presented from the head entry so a pop can load it directly.
module mon_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mon_framer.sv
// Buffers monitor samples and emits SYNC / seq / FRAME_LEN-sample frames
// on a registered valid/ready stream, counting samples dropped when full.
module uart_mon_framer
    import uart_mon_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          FRAME_LEN = 8,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [15:0]            in_data,
    input  logic                   in_valid,
    output logic [15:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [7:0]             drop_cnt,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy
);

    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

    mon_state_t  state;
    mon_state_t  state_nxt;
    logic [15:0] data_nxt;
    logic        valid_nxt;
    logic [15:0] seq;
    logic [15:0] seq_nxt;
    logic [7:0]  data_cnt;
    logic [7:0]  cnt_nxt;
    logic        pop;
    logic        xfer;
    logic        drop;
    logic [15:0] fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;

    mon_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign xfer = out_valid && out_ready;
    assign drop = in_valid && fifo_full;
    assign busy = (state != IDLE);

    // Frame sequencing: choose the next output word and when to pop.
    always_comb begin
        state_nxt = state;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        seq_nxt   = seq;
        cnt_nxt   = data_cnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = HDR;
                    data_nxt  = SYNC_WORD;
                    valid_nxt = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_nxt = SEQ;
                    data_nxt  = seq;
                end
            end
            SEQ: begin
                if (xfer) begin
                    state_nxt = DATA;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        data_nxt  = fifo_rd;
                        valid_nxt = 1'b1;
                    end else begin
                        valid_nxt = 1'b0;
                    end
                end
            end
            DATA: begin
                if (xfer && data_cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    cnt_nxt   = 8'd0;
                    seq_nxt   = seq + 16'd1;
                end else begin
                    if (xfer) begin
                        cnt_nxt = data_cnt + 8'd1;
                    end
                    if ((!out_valid || xfer) && !fifo_empty) begin
                        pop       = 1'b1;
                        data_nxt  = fifo_rd;
                        valid_nxt = 1'b1;
                    end else if (xfer) begin
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, output register, sequence number and data counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= 16'd0;
            out_valid <= 1'b0;
            seq       <= 16'd0;
            data_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            seq       <= seq_nxt;
            data_cnt  <= cnt_nxt;
        end
    end

    // Drop accounting; a clear pulse wins over a coincident drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_mon_framer.sv
// Randomized bench for uart_mon_framer against a queue-based stream model.
// Expected words come from frame rules: SYNC, seq, then buffered samples.
module tb_uart_mon_framer;

    localparam int          DEPTH = 16;
    localparam int          FLEN  = 8;
    localparam logic [15:0] SYNC  = 16'hA55A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        clr_ovf;
    logic [7:0]  drop_cnt;
    logic [4:0]  fifo_level;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;

    logic [15:0] exp_q[$];
    int          pos  = 0;
    logic [15:0] mseq = 16'd0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data  = 16'd0;

    uart_mon_framer #(
        .DEPTH     (DEPTH),
        .FRAME_LEN (FLEN),
        .SYNC_WORD (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: every accepted word must match the frame model.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (pos == 0) begin
                    chk("stream_sync", 32'(out_data), 32'(SYNC));
                end else if (pos == 1) begin
                    chk("stream_seq", 32'(out_data), 32'(mseq));
                end else if (exp_q.size() == 0) begin
                    chk("stream_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", 32'(out_data), 32'(e));
                end
                pos++;
                if (pos == FLEN + 2) begin
                    pos  = 0;
                    mseq = mseq + 16'd1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [15:0] d, bit acc);
        in_valid = 1'b1;
        in_data  = d;
        if (acc) exp_q.push_back(d);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(string tag, bit need_empty, bit rnd, int budget);
        int n = 0;
        while (n < budget &&
               !(pos == 0 && !busy && (!need_empty || exp_q.size() == 0))) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_pos(string tag, int target, int budget);
        int n = 0;
        while (n < budget && pos < target) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int pushed;
        int n;
        int bad;
        rst_n     = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cyc();

        // first-sample latency, then two frames 0001..0008 and 0101..0108
        enable = 1'b1;
        push(16'h0001, 1'b1);
        chk("lat_level", 32'(fifo_level), 32'd1);
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("lat_n2_data", 32'(out_data), 32'(SYNC));
        for (int i = 2; i <= 8; i++) push(16'(i), 1'b1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(16'(16'h0100 + i), 1'b1);
        wait_done("frames12_done", 1'b1, 1'b0, 200);
        chk("frames12_busy", 32'(busy), 32'd0);

        // random back-pressure and random sample timing
        pushed = 0;
        n = 0;
        while (pushed < 3 * FLEN && n < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                push(16'($urandom), 1'b1);
                pushed++;
            end else begin
                cyc();
            end
            n++;
        end
        chk("rand_pushed", 32'(pushed), 32'(3 * FLEN));
        wait_done("rand_done", 1'b1, 1'b1, 1000);
        chk("rand_ovf", 32'(overflow), 32'd0);
        chk("rand_drop", 32'(drop_cnt), 32'd0);

        // enable dropped after the 3rd data word: frame completes, rest stays
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(16'(16'h0300 + i), 1'b1);
        out_ready = 1'b1;
        wait_pos("en_pos", 5, 100);
        enable = 1'b0;
        wait_done("en_frame_end", 1'b0, 1'b0, 100);
        chk("en_level", 32'(fifo_level), 32'd4);
        bad = 0;
        repeat (10) begin
            cyc();
            if (out_valid || busy) bad++;
        end
        chk("en_stays_idle", 32'(bad), 32'd0);

        // starved mid-DATA, then asynchronous reset
        enable = 1'b1;
        wait_pos("mid_pos", 6, 100);
        repeat (3) cyc();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_starved", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        exp_q.delete();
        pos  = 0;
        mseq = 16'd0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // overflow: 20 samples with the stream stalled at the header
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) push(16'(16'h2000 + i), i < DEPTH);
        chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
        chk("ovf_drop", 32'(drop_cnt), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        push(16'hDEAD, 1'b0);
        clr_ovf = 1'b0;
        chk("clr_race_flag", 32'(overflow), 32'd0);
        chk("clr_race_drop", 32'(drop_cnt), 32'd0);
        push(16'hBEEF, 1'b0);
        chk("drop1_cnt", 32'(drop_cnt), 32'd1);
        chk("drop1_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 260; i++) push(16'(i), 1'b0);
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("clr_flag", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        wait_done("ovf_drain", 1'b1, 1'b0, 300);
        chk("end_level", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
